// File: rtl/obi_data_mem_responder_if.sv
// OBI data-side bus between an LSU initiator and a data memory responder.
// The address phase is req/gnt and the response phase is rvalid.
interface obi_data_mem_responder_if;
  logic        data_req_i;
  logic [31:0] data_addr_i;
  logic        data_we_i;
  logic [3:0]  data_be_i;
  logic [31:0] data_wdata_i;
  logic        data_gnt_o;
  logic        data_rvalid_o;
  logic [31:0] data_rdata_o;
  logic        data_err_o;

  modport master (
    output data_req_i, data_addr_i, data_we_i, data_be_i, data_wdata_i,
    input  data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o
  );

  modport slave (
    input  data_req_i, data_addr_i, data_we_i, data_be_i, data_wdata_i,
    output data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o
  );
endinterface

// File: rtl/obi_data_mem_responder.sv
// Word-organised data memory that answers OBI data requests.
// - Grants can be delayed by a programmable stall on each new request.
// - Responses are pipelined a fixed number of cycles and arrive strictly in order.
// - The number of granted-but-unanswered transactions is bounded.
module obi_data_mem_responder #(
  parameter int MEM_DEPTH       = 1024,
  parameter int RESP_LATENCY    = 1,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  obi_data_mem_responder_if.slave        bus,
  input  logic [3:0]                     gnt_stall_i,
  output logic                           busy_o
);

  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic {
    ST_IDLE,
    ST_STALL
  } state_e;

  state_e            state_q, state_d;
  logic [3:0]        stall_q, stall_d;
  logic [CNT_W-1:0]  out_cnt_q;
  logic              gnt;
  logic              accept;
  logic              can_grant;
  logic              in_range;
  logic              rvalid;
  logic [29:0]       word_addr;
  logic [IDX_W-1:0]  word_idx;
  logic [31:0]       rd_word;
  logic              unused_addr_lsb;

  logic [31:0]             mem [MEM_DEPTH];
  logic [RESP_LATENCY-1:0] pipe_vld_q;
  logic [RESP_LATENCY-1:0] pipe_err_q;
  logic [31:0]             pipe_rdata_q [RESP_LATENCY];

  // The byte offset inside a word never selects anything.
  assign unused_addr_lsb = ^bus.data_addr_i[1:0];

  assign word_addr = bus.data_addr_i[31:2];
  assign word_idx  = word_addr[IDX_W-1:0];
  assign in_range  = (word_addr < 30'(MEM_DEPTH));
  // A retiring response does not free a slot in its own cycle.
  assign can_grant = (out_cnt_q < CNT_W'(MAX_OUTSTANDING));
  assign accept    = bus.data_req_i && gnt;
  assign rvalid    = pipe_vld_q[RESP_LATENCY-1];

  // Grant FSM: next state, stall countdown and the combinational grant.
  // NOTE: every output of this block gets a default first so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    stall_d = stall_q;
    gnt     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.data_req_i) begin
          if (gnt_stall_i == 4'd0) begin
            gnt = can_grant;
          end else begin
            state_d = ST_STALL;
            stall_d = gnt_stall_i - 4'd1;
          end
        end
      end
      ST_STALL: begin
        if (!bus.data_req_i) begin
          state_d = ST_IDLE;
        end else if (stall_q != 4'd0) begin
          stall_d = stall_q - 4'd1;
        end else begin
          gnt = can_grant;
          if (can_grant) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Grant FSM state and stall counter registers.
  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      stall_q <= 4'd0;
    end else begin
      state_q <= state_d;
      stall_q <= stall_d;
    end
  end

  // Outstanding transaction count: up on acceptance, down on response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_cnt_q <= '0;
    end else if (accept && !rvalid) begin
      out_cnt_q <= out_cnt_q + CNT_W'(1);
    end else if (!accept && rvalid) begin
      out_cnt_q <= out_cnt_q - CNT_W'(1);
    end
  end

  // Byte-enabled write into the storage array on an accepted in-range write.
  // NOTE: the storage array has no reset; its contents survive rst_n and only the control state is cleared.
  always_ff @(posedge clk) begin
    if (accept && bus.data_we_i && in_range) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.data_be_i[b]) mem[word_idx][8*b +: 8] <= bus.data_wdata_i[8*b +: 8];
      end
    end
  end

  // Read word that enters the response pipe; writes and errors carry zero.
  always_comb begin
    rd_word = '0;
    if (accept && !bus.data_we_i && in_range) rd_word = mem[word_idx];
  end

  // Response pipe: stage 0 loads at acceptance, the last stage drives rvalid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_vld_q <= '0;
      pipe_err_q <= '0;
      for (int i = 0; i < RESP_LATENCY; i++) pipe_rdata_q[i] <= '0;
    end else begin
      pipe_vld_q[0]   <= accept;
      pipe_err_q[0]   <= accept && !in_range;
      pipe_rdata_q[0] <= rd_word;
      for (int i = 1; i < RESP_LATENCY; i++) begin
        pipe_vld_q[i]   <= pipe_vld_q[i-1];
        pipe_err_q[i]   <= pipe_err_q[i-1];
        pipe_rdata_q[i] <= pipe_rdata_q[i-1];
      end
    end
  end

  assign bus.data_gnt_o    = gnt;
  assign bus.data_rvalid_o = rvalid;
  assign bus.data_rdata_o  = rvalid ? pipe_rdata_q[RESP_LATENCY-1] : 32'd0;
  assign bus.data_err_o    = rvalid && pipe_err_q[RESP_LATENCY-1];
  assign busy_o            = (state_q != ST_IDLE) || (out_cnt_q != '0);

endmodule

// File: tb/tb_obi_data_mem_responder.sv
// Testbench for obi_data_mem_responder: two instances (response latency 1 and 2)
// share one driver; a transaction-level model predicts every response.
module tb_obi_data_mem_responder;

  localparam int MEM_DEPTH = 1024;
  localparam int MAX_OUT   = 2;

  typedef struct {
    int          due;
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [3:0]  stall;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sel;
  logic        req, we;
  logic [31:0] addr, wdata;
  logic [3:0]  be, stall;
  logic        busy0, busy1;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  rsp_t        q[$];
  logic [31:0] ref_mem [2][MEM_DEPTH];
  logic        got_gnt, last_rvalid, obs_busy, last_err;
  logic [31:0] last_rdata;
  int          last_outst;

  always #5 clk = ~clk;

  obi_data_mem_responder_if bus0 ();
  obi_data_mem_responder_if bus1 ();

  assign bus0.data_req_i   = req && !sel;
  assign bus0.data_addr_i  = addr;
  assign bus0.data_we_i    = we;
  assign bus0.data_be_i    = be;
  assign bus0.data_wdata_i = wdata;
  assign bus1.data_req_i   = req && sel;
  assign bus1.data_addr_i  = addr;
  assign bus1.data_we_i    = we;
  assign bus1.data_be_i    = be;
  assign bus1.data_wdata_i = wdata;

  obi_data_mem_responder #(
    .MEM_DEPTH(MEM_DEPTH), .RESP_LATENCY(1), .MAX_OUTSTANDING(MAX_OUT)
  ) u_dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0), .gnt_stall_i(stall), .busy_o(busy0)
  );

  obi_data_mem_responder #(
    .MEM_DEPTH(MEM_DEPTH), .RESP_LATENCY(2), .MAX_OUTSTANDING(MAX_OUT)
  ) u_dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1), .gnt_stall_i(stall), .busy_o(busy1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d, dut %0d)", name, act, exp, cyc, sel);
    end
  endtask

  // Sample the selected instance once per cycle and run the reference model.
  task automatic observe();
    logic        g, v, e;
    logic [31:0] d;
    rsp_t        r;
    int unsigned widx;
    g = sel ? bus1.data_gnt_o    : bus0.data_gnt_o;
    v = sel ? bus1.data_rvalid_o : bus0.data_rvalid_o;
    d = sel ? bus1.data_rdata_o  : bus0.data_rdata_o;
    e = sel ? bus1.data_err_o    : bus0.data_err_o;
    last_outst  = q.size();
    got_gnt     = g;
    last_rvalid = v;
    obs_busy    = sel ? busy1 : busy0;
    if (q.size() >= MAX_OUT) check("gnt_when_full", 32'(g), 32'd0);
    if (v) begin
      check("rvalid_expected", 32'(q.size() != 0), 32'd1);
      if (q.size() != 0) begin
        r = q.pop_front();
        check("rsp_cycle", 32'(cyc), 32'(r.due));
        check("rsp_rdata", d, r.rdata);
        check("rsp_err", 32'(e), 32'(r.err));
      end
      last_rdata = d;
      last_err   = e;
    end else begin
      check("idle_rdata", d, 32'd0);
      check("idle_err", 32'(e), 32'd0);
      if (q.size() != 0 && q[0].due <= cyc) begin
        check("rsp_missing", 32'(v), 32'd1);
        void'(q.pop_front());
      end
    end
    if (req && g) begin
      widx = addr[31:2];
      r.due = cyc + (sel ? 2 : 1);
      if (widx >= MEM_DEPTH) begin
        r.rdata = 32'd0;
        r.err   = 1'b1;
      end else begin
        r.err = 1'b0;
        if (we) begin
          for (int b = 0; b < 4; b++)
            if (be[b]) ref_mem[int'(sel)][widx][8*b +: 8] = wdata[8*b +: 8];
          r.rdata = 32'd0;
        end else begin
          r.rdata = ref_mem[int'(sel)][widx];
        end
      end
      q.push_back(r);
    end
  endtask

  // Inputs are set by the caller just after a rising edge; sample on the falling edge.
  task automatic tick();
    @(negedge clk);
    observe();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  // Hold one request until granted. Side-band fields are scrambled during the
  // stall window to show only the values present at acceptance matter.
  task automatic do_req(input logic w, input logic [31:0] a, input logic [3:0] b,
                        input logic [31:0] d, input logic [3:0] s);
    int k = 0;
    bit done = 1'b0;
    req   = 1'b1;
    stall = s;
    while (!done && k < 40) begin
      if (k == 1) stall = 4'd0;
      if (k < int'(s)) begin
        we = 1'($urandom); addr = $urandom; be = 4'($urandom); wdata = $urandom;
      end else begin
        we = w; addr = a; be = b; wdata = d;
      end
      tick();
      check("gnt_timing", 32'(got_gnt), 32'((k >= int'(s)) && (last_outst < MAX_OUT)));
      done = got_gnt;
      k++;
    end
    if (!done) check("gnt_timeout", 32'(got_gnt), 32'd1);
    req   = 1'b0;
    stall = 4'd0;
  endtask

  task automatic drain();
    int k = 0;
    req = 1'b0;
    while (q.size() != 0 && k < 20) begin
      tick();
      k++;
    end
    if (q.size() != 0) begin
      check("drain_timeout", 32'(q.size()), 32'd0);
      q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin : main
    vec_t        vecs [11];
    logic        exp_g [6];
    logic        exp_v [6];
    logic [31:0] exp_d [6];
    int          idx;
    logic [31:0] a;

    sel = 1'b0; req = 1'b0; we = 1'b0; addr = '0; be = '0; wdata = '0; stall = '0;

    // Reset state of both instances.
    repeat (2) @(posedge clk);
    #1;
    check("rst_rvalid0", 32'(bus0.data_rvalid_o), 32'd0);
    check("rst_rdata0",  bus0.data_rdata_o, 32'd0);
    check("rst_err0",    32'(bus0.data_err_o), 32'd0);
    check("rst_busy0",   32'(busy0), 32'd0);
    check("rst_rvalid1", 32'(bus1.data_rvalid_o), 32'd0);
    check("rst_busy1",   32'(busy1), 32'd0);
    rst_n = 1'b1;
    tick();

    // Single transactions on the latency-1 instance, each drained before the next.
    vecs[0]  = '{1'b1, 32'h0000_0010, 4'hF, 32'hDEAD_BEEF, 4'd0, 32'h0000_0000, 1'b0};
    vecs[1]  = '{1'b0, 32'h0000_0010, 4'hF, 32'h0000_0000, 4'd0, 32'hDEAD_BEEF, 1'b0};
    vecs[2]  = '{1'b1, 32'h0000_0010, 4'h4, 32'h00AA_0000, 4'd0, 32'h0000_0000, 1'b0};
    vecs[3]  = '{1'b0, 32'h0000_0010, 4'hF, 32'h0000_0000, 4'd0, 32'hDEAA_BEEF, 1'b0};
    vecs[4]  = '{1'b1, 32'h0000_0FFC, 4'hF, 32'h1234_5678, 4'd1, 32'h0000_0000, 1'b0};
    vecs[5]  = '{1'b1, 32'h0000_1000, 4'hF, 32'hFFFF_FFFF, 4'd0, 32'h0000_0000, 1'b1};
    vecs[6]  = '{1'b0, 32'h0000_0FFC, 4'hF, 32'h0000_0000, 4'd2, 32'h1234_5678, 1'b0};
    vecs[7]  = '{1'b0, 32'h0000_1000, 4'hF, 32'h0000_0000, 4'd0, 32'h0000_0000, 1'b1};
    vecs[8]  = '{1'b1, 32'h0000_0020, 4'hF, 32'h0000_0000, 4'd1, 32'h0000_0000, 1'b0};
    vecs[9]  = '{1'b1, 32'h0000_0023, 4'h3, 32'hAABB_CCDD, 4'd2, 32'h0000_0000, 1'b0};
    vecs[10] = '{1'b0, 32'h0000_0020, 4'hF, 32'h0000_0000, 4'd3, 32'h0000_CCDD, 1'b0};
    foreach (vecs[i]) begin
      do_req(vecs[i].we, vecs[i].addr, vecs[i].be, vecs[i].wdata, vecs[i].stall);
      drain();
      check($sformatf("vec%0d_rdata", i), last_rdata, vecs[i].exp_rdata);
      check($sformatf("vec%0d_err", i), 32'(last_err), 32'(vecs[i].exp_err));
    end

    // Write followed by a read of the same word in the very next cycle.
    do_req(1'b1, 32'h0000_0040, 4'hF, 32'hCAFE_F00D, 4'd0);
    do_req(1'b0, 32'h0000_0040, 4'hF, 32'h0, 4'd0);
    drain();
    check("raw_next_cycle", last_rdata, 32'hCAFE_F00D);

    // Stall of 3: grant in cycle 3, response in cycle 4, busy in cycles 1..4.
    req = 1'b1; we = 1'b0; addr = 32'h10; be = 4'hF; stall = 4'd3;
    for (int c = 0; c < 6; c++) begin
      if (c == 1) stall = 4'd0;
      if (c == 4) req = 1'b0;
      tick();
      check($sformatf("stall3_gnt_c%0d", c),    32'(got_gnt),     32'(c == 3));
      check($sformatf("stall3_rvalid_c%0d", c), 32'(last_rvalid), 32'(c == 4));
      check($sformatf("stall3_busy_c%0d", c),   32'(obs_busy),    32'(c >= 1 && c <= 4));
    end
    check("stall3_rdata", last_rdata, 32'hDEAA_BEEF);
    drain();

    // Latency 2, two outstanding: back-to-back reads hit the outstanding limit.
    sel = 1'b1;
    do_req(1'b1, 32'h0, 4'hF, 32'd1, 4'd0);
    do_req(1'b1, 32'h4, 4'hF, 32'd2, 4'd0);
    do_req(1'b1, 32'h8, 4'hF, 32'd3, 4'd0);
    drain();
    exp_g = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    exp_v = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    exp_d = '{32'd0, 32'd0, 32'd1, 32'd2, 32'd0, 32'd3};
    idx = 0;
    we = 1'b0; be = 4'hF; stall = 4'd0;
    for (int c = 0; c < 6; c++) begin
      req  = (idx < 3);
      addr = 32'(idx * 4);
      tick();
      check($sformatf("full_gnt_c%0d", c),    32'(got_gnt),     32'(exp_g[c]));
      check($sformatf("full_rvalid_c%0d", c), 32'(last_rvalid), 32'(exp_v[c]));
      if (exp_v[c]) check($sformatf("full_rdata_c%0d", c), last_rdata, exp_d[c]);
      if (got_gnt) idx++;
    end
    drain();

    // Reset between grant and response: the response is discarded, memory survives.
    do_req(1'b0, 32'h4, 4'hF, 32'h0, 4'd0);
    rst_n = 1'b0;
    q.delete();
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      check($sformatf("post_rst_rvalid_c%0d", c), 32'(last_rvalid), 32'd0);
      check($sformatf("post_rst_busy_c%0d", c),   32'(obs_busy),    32'd0);
    end
    do_req(1'b0, 32'h0, 4'hF, 32'h0, 4'd0);
    drain();
    check("mem_kept_over_reset", last_rdata, 32'd1);

    // Randomised traffic on both instances against the transaction model.
    for (int s = 0; s < 2; s++) begin
      sel = 1'(s);
      for (int i = 0; i < 16; i++) do_req(1'b1, 32'h100 + 32'(4 * i), 4'hF, $urandom, 4'd0);
      for (int n = 0; n < 150; n++) begin
        if ($urandom_range(0, 4) == 0) a = $urandom | 32'h0000_1000;
        else a = 32'h100 + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
        do_req(1'($urandom), a, 4'($urandom), $urandom, 4'($urandom_range(0, 3)));
        repeat ($urandom_range(0, 2)) tick();
      end
      drain();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
